// File: rtl/mmu_pkg.sv
// Shared types for the MMU permission-check slice.
package mmu_pkg;

    typedef enum logic [1:0] {
        FAULT_NONE   = 2'b00,
        FAULT_DOMAIN = 2'b01,
        FAULT_PERM   = 2'b10
    } fault_e;

    typedef enum logic [1:0] {
        DOM_NOACC   = 2'b00,
        DOM_CLIENT  = 2'b01,
        DOM_RSVD    = 2'b10,
        DOM_MANAGER = 2'b11
    } dom_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    typedef struct packed {
        logic       id;
        logic [3:0] domin;
        logic [1:0] ap;
        logic       apx;
        logic       write;
        logic       priv;
    } req_t;

endpackage

// File: rtl/perm_decode.sv
// Domain lookup plus AP/APX access decision for one request.
module perm_decode
    import mmu_pkg::*;
(
    input  logic [31:0] dacr,
    input  logic [3:0]  domin,
    input  logic [1:0]  ap,
    input  logic        apx,
    input  logic        priv,
    input  logic        write,
    output logic [1:0]  domain_ctrl,
    output logic [1:0]  fault
);

    logic rd_ok;
    logic wr_ok;

    always_comb begin
        domain_ctrl = dacr[{domin, 1'b0} +: 2];
        rd_ok = 1'b0;
        wr_ok = 1'b0;
        unique case ({apx, ap})
            3'b001: begin rd_ok = priv; wr_ok = priv; end
            3'b010: begin rd_ok = 1'b1; wr_ok = priv; end
            3'b011: begin rd_ok = 1'b1; wr_ok = 1'b1; end
            3'b101: rd_ok = priv;
            3'b110: rd_ok = 1'b1;
            default: ;
        endcase
        fault = FAULT_NONE;
        unique case (domain_ctrl)
            DOM_MANAGER: fault = FAULT_NONE;
            DOM_CLIENT: begin
                if (write ? !wr_ok : !rd_ok)
                    fault = FAULT_PERM;
            end
            default: fault = FAULT_DOMAIN;
        endcase
    end

endmodule

// File: rtl/perm_check_arbiter.sv
// Round-robin arbiter sharing one permission checker between the
// data-side (port 0) and instruction-side (port 1) MMU requesters.
module perm_check_arbiter
    import mmu_pkg::*;
#(
    parameter logic [31:0] DACR_RST    = 32'h0000_0000,
    parameter int          FAULT_CNT_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req0_valid,
    output logic                   o_req0_ready,
    input  logic [3:0]             i_req0_domin,
    input  logic [1:0]             i_req0_ap,
    input  logic                   i_req0_apx,
    input  logic                   i_req0_write,
    input  logic                   i_req0_priv,
    input  logic                   i_req1_valid,
    output logic                   o_req1_ready,
    input  logic [3:0]             i_req1_domin,
    input  logic [1:0]             i_req1_ap,
    input  logic                   i_req1_apx,
    input  logic                   i_req1_write,
    input  logic                   i_req1_priv,
    input  logic                   i_dacr_we,
    input  logic [31:0]            i_dacr_wdata,
    output logic [31:0]            o_dacr,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic                   o_rsp_id,
    output logic                   o_rsp_ok,
    output logic [1:0]             o_rsp_fault,
    output logic [1:0]             o_domain_ctrl,
    output logic [FAULT_CNT_W-1:0] o_fault_cnt
);

    state_e     state;
    logic       pref;
    logic       grant;
    logic       accept;
    req_t       req_q;
    req_t       req_new;
    logic [1:0] dec_ctrl;
    logic [1:0] dec_fault;

    // Both valid: take the preferred port; otherwise take whichever is valid.
    always_comb begin
        grant = pref;
        if (i_req0_valid && !i_req1_valid)
            grant = 1'b0;
        else if (!i_req0_valid && i_req1_valid)
            grant = 1'b1;
        o_req0_ready = (state == ST_IDLE) && !i_rst && i_req0_valid && !grant;
        o_req1_ready = (state == ST_IDLE) && !i_rst && i_req1_valid && grant;
        accept = o_req0_ready || o_req1_ready;
        if (grant)
            req_new = '{1'b1, i_req1_domin, i_req1_ap, i_req1_apx, 1'b0,
                        i_req1_priv};
        else
            req_new = '{1'b0, i_req0_domin, i_req0_ap, i_req0_apx,
                        i_req0_write, i_req0_priv};
    end

    perm_decode u_decode (
        .dacr        (o_dacr),
        .domin       (req_q.domin),
        .ap          (req_q.ap),
        .apx         (req_q.apx),
        .priv        (req_q.priv),
        .write       (req_q.write),
        .domain_ctrl (dec_ctrl),
        .fault       (dec_fault)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_dacr <= DACR_RST;
        else if (i_dacr_we)
            o_dacr <= i_dacr_wdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            pref          <= 1'b0;
            req_q         <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_id      <= 1'b0;
            o_rsp_ok      <= 1'b0;
            o_rsp_fault   <= FAULT_NONE;
            o_domain_ctrl <= DOM_NOACC;
            o_fault_cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_q <= req_new;
                        pref  <= ~grant;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    o_rsp_valid   <= 1'b1;
                    o_rsp_id      <= req_q.id;
                    o_rsp_ok      <= (dec_fault == FAULT_NONE);
                    o_rsp_fault   <= dec_fault;
                    o_domain_ctrl <= dec_ctrl;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= ST_IDLE;
                        if (o_rsp_fault != FAULT_NONE && o_fault_cnt != '1)
                            o_fault_cnt <= o_fault_cnt + FAULT_CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
